// File: rtl/ycr2_router_n.sv
// N-master to 1-slave memory router: filters requests by target id, arbitrates
// (round-robin or fixed priority), holds the grant until LOK/ER, and guards BUSY with a watchdog.
module ycr2_router_n #(
  parameter int NM       = 4,
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int BW       = 3,
  parameter int TIDW     = 3,
  parameter int ARB_MODE = 0,
  parameter int TMO      = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [TIDW-1:0]   target_id,
  input  logic [NM-1:0]     m_req,
  input  logic [NM*TIDW-1:0] m_tid,
  input  logic [NM-1:0]     m_cmd,
  input  logic [NM*2-1:0]   m_width,
  input  logic [NM*AW-1:0]  m_addr,
  input  logic [NM*BW-1:0]  m_bl,
  input  logic [NM*DW-1:0]  m_wdata,
  output logic [NM-1:0]     m_req_ack,
  output logic [NM-1:0]     m_lack,
  output logic [NM*DW-1:0]  m_rdata,
  output logic [NM*2-1:0]   m_resp,
  output logic              core_req,
  output logic              core_cmd,
  output logic [1:0]        core_width,
  output logic [AW-1:0]     core_addr,
  output logic [BW-1:0]     core_bl,
  output logic [DW-1:0]     core_wdata,
  input  logic              core_req_ack,
  input  logic [DW-1:0]     core_rdata,
  input  logic [1:0]        core_resp
);

  localparam int GW = (NM > 1) ? $clog2(NM) : 1;
  localparam int CW = (TMO > 1) ? $clog2(TMO) : 1;

  localparam logic [1:0] RESP_NOTRDY = 2'd0;
  localparam logic [1:0] RESP_ER     = 2'd2;
  localparam logic [1:0] RESP_LOK    = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ERR  = 2'd2
  } state_t;

  state_t         state;
  logic [GW-1:0]  gidx;
  logic [GW-1:0]  rr_ptr;
  logic [CW-1:0]  wd_cnt;

  logic [NM-1:0]  req_t;
  logic           any_req;
  logic [GW-1:0]  pick;
  logic           found;
  logic [GW:0]    cand_sum;
  logic [GW-1:0]  cand;
  logic [GW-1:0]  sel;
  logic           busy;
  logic           err;
  logic           activity;
  logic           wd_hit;

  logic           cmd_a   [NM];
  logic [1:0]     width_a [NM];
  logic [AW-1:0]  addr_a  [NM];
  logic [BW-1:0]  bl_a    [NM];
  logic [DW-1:0]  wdata_a [NM];

  assign busy     = (state == BUSY);
  assign err      = (state == ERR);
  assign any_req  = |req_t;
  assign activity = core_req_ack || (core_resp != RESP_NOTRDY);
  assign wd_hit   = (TMO != 0) && (wd_cnt == CW'(TMO - 1));

  // Per-master filtering, field unpacking and response steering
  genvar gi;
  generate
    for (gi = 0; gi < NM; gi++) begin : g_m
      logic hit;

      assign req_t[gi]   = m_req[gi] && (m_tid[gi*TIDW +: TIDW] == target_id);
      assign cmd_a[gi]   = m_cmd[gi];
      assign width_a[gi] = m_width[gi*2 +: 2];
      assign addr_a[gi]  = m_addr[gi*AW +: AW];
      assign bl_a[gi]    = m_bl[gi*BW +: BW];
      assign wdata_a[gi] = m_wdata[gi*DW +: DW];

      assign hit = (gidx == GW'(gi));

      assign m_req_ack[gi]         = busy && hit && core_req_ack;
      assign m_lack[gi]            = hit && ((busy && (core_resp == RESP_LOK)) || err);
      assign m_rdata[gi*DW +: DW]  = (busy && hit) ? core_rdata : '0;
      assign m_resp[gi*2 +: 2]     = !hit ? RESP_NOTRDY :
                                     busy ? core_resp   :
                                     err  ? RESP_ER     : RESP_NOTRDY;
    end
  endgenerate

  // Arbitration: candidate order starts at rr_ptr (RR) or at 0 (fixed priority)
  always_comb begin
    pick     = '0;
    found    = 1'b0;
    cand_sum = '0;
    cand     = '0;
    for (int k = 0; k < NM; k++) begin
      if (ARB_MODE == 1) begin
        cand_sum = (GW+1)'(k);
      end else begin
        cand_sum = {1'b0, rr_ptr} + (GW+1)'(k);
        if (cand_sum >= (GW+1)'(NM)) begin
          cand_sum = cand_sum - (GW+1)'(NM);
        end
      end
      cand = cand_sum[GW-1:0];
      if (!found && req_t[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

  // Slave-side mux; in IDLE the fields follow rr_ptr and core_req stays low
  assign sel        = (state == IDLE) ? rr_ptr : gidx;
  assign core_req   = busy && req_t[gidx];
  assign core_cmd   = cmd_a[sel];
  assign core_width = width_a[sel];
  assign core_addr  = addr_a[sel];
  assign core_bl    = bl_a[sel];
  assign core_wdata = wdata_a[sel];

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      gidx   <= '0;
      rr_ptr <= '0;
      wd_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            state  <= BUSY;
            gidx   <= pick;
            wd_cnt <= '0;
            if (ARB_MODE == 0) begin
              rr_ptr <= (pick == GW'(NM - 1)) ? '0 : pick + GW'(1);
            end
          end
        end
        BUSY: begin
          if (core_resp == RESP_LOK || core_resp == RESP_ER) begin
            state <= IDLE;
          end else if (activity) begin
            wd_cnt <= '0;
          end else if (wd_hit) begin
            state <= ERR;
          end else if (TMO != 0) begin
            wd_cnt <= wd_cnt + CW'(1);
          end
        end
        ERR: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ycr2_router_n.sv
// Directed bench for ycr2_router_n: a round-robin instance (TMO=8) and a fixed-priority
// instance share the master/slave stimulus; expected grants and responses go through queues.
module tb_ycr2_router_n;

  localparam int NM   = 4;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int BW   = 3;
  localparam int TIDW = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [TIDW-1:0]   target_id = 3'd2;
  logic [NM-1:0]     m_req = '0;
  logic [NM*TIDW-1:0] m_tid = '0;
  logic [NM-1:0]     m_cmd = '0;
  logic [NM*2-1:0]   m_width = '0;
  logic [NM*AW-1:0]  m_addr = '0;
  logic [NM*BW-1:0]  m_bl = '0;
  logic [NM*DW-1:0]  m_wdata = '0;
  logic              core_req_ack = 1'b0;
  logic [DW-1:0]     core_rdata = '0;
  logic [1:0]        core_resp = 2'd0;

  logic [NM-1:0]    r_m_req_ack, f_m_req_ack, o_m_req_ack;
  logic [NM-1:0]    r_m_lack, f_m_lack, o_m_lack;
  logic [NM*DW-1:0] r_m_rdata, f_m_rdata, o_m_rdata;
  logic [NM*2-1:0]  r_m_resp, f_m_resp, o_m_resp;
  logic             r_core_req, f_core_req, o_core_req;
  logic             r_core_cmd, f_core_cmd, o_core_cmd;
  logic [1:0]       r_core_width, f_core_width, o_core_width;
  logic [AW-1:0]    r_core_addr, f_core_addr, o_core_addr;
  logic [BW-1:0]    r_core_bl, f_core_bl, o_core_bl;
  logic [DW-1:0]    r_core_wdata, f_core_wdata, o_core_wdata;

  logic use_fp = 1'b0;

  assign o_m_req_ack  = use_fp ? f_m_req_ack  : r_m_req_ack;
  assign o_m_lack     = use_fp ? f_m_lack     : r_m_lack;
  assign o_m_rdata    = use_fp ? f_m_rdata    : r_m_rdata;
  assign o_m_resp     = use_fp ? f_m_resp     : r_m_resp;
  assign o_core_req   = use_fp ? f_core_req   : r_core_req;
  assign o_core_cmd   = use_fp ? f_core_cmd   : r_core_cmd;
  assign o_core_width = use_fp ? f_core_width : r_core_width;
  assign o_core_addr  = use_fp ? f_core_addr  : r_core_addr;
  assign o_core_bl    = use_fp ? f_core_bl    : r_core_bl;
  assign o_core_wdata = use_fp ? f_core_wdata : r_core_wdata;

  ycr2_router_n #(.NM(NM), .AW(AW), .DW(DW), .BW(BW), .TIDW(TIDW), .ARB_MODE(0), .TMO(8)) dut_rr (
    .clk(clk), .rst(rst), .target_id(target_id),
    .m_req(m_req), .m_tid(m_tid), .m_cmd(m_cmd), .m_width(m_width), .m_addr(m_addr),
    .m_bl(m_bl), .m_wdata(m_wdata),
    .m_req_ack(r_m_req_ack), .m_lack(r_m_lack), .m_rdata(r_m_rdata), .m_resp(r_m_resp),
    .core_req(r_core_req), .core_cmd(r_core_cmd), .core_width(r_core_width),
    .core_addr(r_core_addr), .core_bl(r_core_bl), .core_wdata(r_core_wdata),
    .core_req_ack(core_req_ack), .core_rdata(core_rdata), .core_resp(core_resp)
  );

  ycr2_router_n #(.NM(NM), .AW(AW), .DW(DW), .BW(BW), .TIDW(TIDW), .ARB_MODE(1), .TMO(0)) dut_fp (
    .clk(clk), .rst(rst), .target_id(target_id),
    .m_req(m_req), .m_tid(m_tid), .m_cmd(m_cmd), .m_width(m_width), .m_addr(m_addr),
    .m_bl(m_bl), .m_wdata(m_wdata),
    .m_req_ack(f_m_req_ack), .m_lack(f_m_lack), .m_rdata(f_m_rdata), .m_resp(f_m_resp),
    .core_req(f_core_req), .core_cmd(f_core_cmd), .core_width(f_core_width),
    .core_addr(f_core_addr), .core_bl(f_core_bl), .core_wdata(f_core_wdata),
    .core_req_ack(core_req_ack), .core_rdata(core_rdata), .core_resp(core_resp)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         m;
    logic [1:0] resp;
    logic       lack;
    logic       ack;
    logic [31:0] rdata;
  } exp_t;

  exp_t sbq[$];
  int   gq[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [31:0] addr_of(input int m);
    return 32'h4000_0000 + 32'(m) * 32'h100;
  endfunction

  function automatic logic [31:0] wdata_of(input int m);
    return 32'hA5A5_0000 + 32'(m);
  endfunction

  function automatic logic [2:0] bl_of(input int m);
    return (m == 2) ? 3'd4 : 3'd1;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, "_core_req"}, o_core_req, 1'b0);
    chk({tag, "_m_ack_lack"}, {o_m_req_ack, o_m_lack}, '0);
    chk({tag, "_m_resp"}, o_m_resp, '0);
    chk({tag, "_m_rdata"}, o_m_rdata[63:0], '0);
    chk({tag, "_m_rdata_hi"}, o_m_rdata[127:64], '0);
  endtask

  task automatic grant_chk(input string tag);
    int m;
    if (gq.size() == 0) begin
      chk({tag, "_grant_queue_empty"}, 1'b1, 1'b0);
      return;
    end
    m = gq.pop_front();
    chk({tag, "_core_req"}, o_core_req, 1'b1);
    chk({tag, "_core_addr"}, o_core_addr, addr_of(m));
    chk({tag, "_core_wdata"}, o_core_wdata, wdata_of(m));
    chk({tag, "_core_bl"}, o_core_bl, bl_of(m));
    chk({tag, "_core_cmd"}, o_core_cmd, m_cmd[m]);
    $display("grant %s master=%0d addr=%0h", tag, m, o_core_addr);
  endtask

  task automatic resp_chk(input string tag);
    exp_t e;
    if (sbq.size() == 0) begin
      chk({tag, "_resp_queue_empty"}, 1'b1, 1'b0);
      return;
    end
    e = sbq.pop_front();
    for (int i = 0; i < NM; i++) begin
      if (i == e.m) begin
        chk($sformatf("%s_resp%0d", tag, i), o_m_resp[i*2 +: 2], e.resp);
        chk($sformatf("%s_lack%0d", tag, i), o_m_lack[i], e.lack);
        chk($sformatf("%s_ack%0d", tag, i), o_m_req_ack[i], e.ack);
        chk($sformatf("%s_rdata%0d", tag, i), o_m_rdata[i*32 +: 32], e.rdata);
      end else begin
        chk($sformatf("%s_quiet%0d", tag, i),
            {o_m_resp[i*2 +: 2], o_m_lack[i], o_m_req_ack[i], o_m_rdata[i*32 +: 32]}, '0);
      end
    end
    $display("beat %s master=%0d resp=%0d lack=%0b", tag, e.m, o_m_resp[e.m*2 +: 2], o_m_lack[e.m]);
  endtask

  task automatic beat(input string tag, input int m, input logic [1:0] r, input logic a,
                      input logic [31:0] d);
    cyc();
    core_resp    = r;
    core_req_ack = a;
    core_rdata   = d;
    sbq.push_back('{m, r, (r == 2'd3), a, d});
    smp();
    resp_chk(tag);
  endtask

  task automatic slave_quiet();
    core_resp    = 2'd0;
    core_req_ack = 1'b0;
    core_rdata   = '0;
  endtask

  task automatic do_reset(input string tag);
    cyc();
    rst = 1'b1;
    slave_quiet();
    m_req = '0;
    cyc();
    smp();
    idle_chk(tag);
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    for (int i = 0; i < NM; i++) begin
      m_tid[i*TIDW +: TIDW] = 3'd2;
      m_addr[i*AW +: AW]    = addr_of(i);
      m_wdata[i*DW +: DW]   = wdata_of(i);
      m_bl[i*BW +: BW]      = bl_of(i);
      m_width[i*2 +: 2]     = 2'b10;
    end
    m_cmd = 4'b1000;

    do_reset("reset0");
    use_fp = 1'b1;
    smp();
    idle_chk("reset0_fp");

    // Fixed priority: 1 and 3 request; 1 wins until it drops
    gq.push_back(1); gq.push_back(1); gq.push_back(1); gq.push_back(3);
    cyc(); m_req = 4'b1010;
    smp(); chk("fp_lat0", o_core_req, 1'b0);
    for (int t = 0; t < 4; t++) begin
      cyc();
      smp(); grant_chk("fp");
      beat("fp", (t < 3) ? 1 : 3, 2'd3, 1'b1, 32'hF000_0000 + 32'(t));
      cyc(); slave_quiet();
      if (t == 2) m_req = 4'b1000;
      if (t == 3) m_req = 4'b0000;
      smp(); idle_chk("fp_dead");
    end

    do_reset("reset1");
    use_fp = 1'b0;

    // RR: masters 0 and 3 -> 0 first, then 3 even though 0 keeps requesting
    gq.push_back(0); gq.push_back(3);
    cyc(); m_req = 4'b1001;
    smp(); chk("rr_lat0", o_core_req, 1'b0);
    cyc(); smp(); grant_chk("rr_first");
    beat("rr_first", 0, 2'd3, 1'b1, 32'h1111_0000);
    cyc(); slave_quiet();
    smp(); idle_chk("rr_dead");
    cyc(); smp(); grant_chk("rr_second");
    beat("rr_second", 3, 2'd3, 1'b1, 32'h3333_0000);
    cyc(); slave_quiet(); m_req = '0;
    smp(); idle_chk("rr_done");

    // Mismatching tid is filtered; slave noise in IDLE is ignored
    cyc(); m_tid[1*TIDW +: TIDW] = 3'd5; m_req = 4'b0010;
    for (int t = 0; t < 20; t++) begin
      cyc();
      core_resp    = (t % 2 == 0) ? 2'd3 : 2'd1;
      core_req_ack = 1'b1;
      core_rdata   = 32'hDEAD_0000 + 32'(t);
      smp();
      chk("tid_core_req", o_core_req, 1'b0);
      chk("tid_ack1", o_m_req_ack[1], 1'b0);
      chk("tid_resp", o_m_resp, '0);
    end
    cyc(); slave_quiet(); m_req = '0; m_tid[1*TIDW +: TIDW] = 3'd2;
    smp(); idle_chk("tid_done");

    // Read burst from master 2 while the others pile up
    gq.push_back(2);
    cyc(); m_req = 4'b0100;
    smp();
    cyc(); smp(); grant_chk("burst");
    m_req = 4'b1111;
    gq.push_back(3);
    beat("burst_b1", 2, 2'd1, 1'b1, 32'hB000_0001);
    beat("burst_b2", 2, 2'd1, 1'b0, 32'hB000_0002);
    beat("burst_b3", 2, 2'd1, 1'b0, 32'hB000_0003);
    chk("burst_hold_addr", o_core_addr, addr_of(2));
    beat("burst_b4", 2, 2'd3, 1'b0, 32'hB000_0004);
    cyc(); slave_quiet();
    smp(); idle_chk("burst_dead");
    cyc(); smp(); grant_chk("after_burst");
    beat("after_burst", 3, 2'd3, 1'b1, 32'h3333_0001);
    cyc(); slave_quiet(); m_req = '0;
    smp(); idle_chk("after_burst_done");

    // Watchdog: 8 silent BUSY cycles, one ERR cycle, then master 2
    gq.push_back(1); gq.push_back(2);
    cyc(); m_req = 4'b0110;
    smp(); chk("wd_lat0", o_core_req, 1'b0);
    for (int t = 0; t < 8; t++) begin
      cyc(); smp();
      if (t == 0) grant_chk("wd");
      else chk($sformatf("wd_busy%0d", t), o_core_req, 1'b1);
    end
    sbq.push_back('{1, 2'd2, 1'b1, 1'b0, 32'h0});
    cyc(); smp();
    chk("wd_err_core_req", o_core_req, 1'b0);
    resp_chk("wd_err");
    cyc(); smp(); idle_chk("wd_idle");
    cyc(); smp(); grant_chk("wd_next");
    beat("wd_next", 2, 2'd3, 1'b1, 32'h2222_0002);
    cyc(); slave_quiet(); m_req = '0;
    smp(); idle_chk("wd_done");

    // Reset during the second beat of a burst
    gq.push_back(2);
    cyc(); m_req = 4'b0100;
    smp();
    cyc(); smp(); grant_chk("rb");
    beat("rb_b1", 2, 2'd1, 1'b1, 32'hC000_0001);
    cyc();
    core_resp = 2'd1; core_req_ack = 1'b0; core_rdata = 32'hC000_0002;
    rst = 1'b1; m_req = 4'b1001;
    sbq.push_back('{2, 2'd1, 1'b0, 1'b0, 32'hC000_0002});
    smp(); resp_chk("rb_b2");
    cyc(); rst = 1'b0; core_resp = 2'd1; core_req_ack = 1'b1;
    smp(); idle_chk("rb_after_rst");
    gq.push_back(0);
    cyc(); slave_quiet();
    smp(); grant_chk("rb_regrant");
    beat("rb_regrant", 0, 2'd3, 1'b1, 32'h0000_ABCD);
    cyc(); slave_quiet(); m_req = '0;
    smp(); idle_chk("rb_done");

    chk("sb_drained", 64'(sbq.size() + gq.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
